// File: rtl/rotator_load_sched.sv
// rotator_load_sched
//   Upstream feeder for an 8-bit rotate-left register stage. Bytes arrive
//   over a valid/ready handshake and are buffered in a small circular FIFO.
//   Each byte is sent to the rotator as a one-cycle load_en pulse carrying
//   load_data. The scheduler then waits HOLD_CYCLES rotate cycles so the
//   downstream stage can finish a full rotation before the next load.
//
//   Optional feature macro: ROTATOR_LOAD_SCHED_FLUSH_EN
//     When defined, the module gains a synchronous active-high flush input.
//     Flush empties the FIFO, returns the FSM to IDLE and clears load_en.
//     A push in the same cycle is dropped, and load_data keeps its value.
//     Reset takes priority over flush.
//
//   Ports:
//     clk        in   single clock; all logic on the rising edge
//     reset      in   synchronous, active-high reset
//     flush      in   synchronous FIFO/FSM flush (only with the macro)
//     in_valid   in   producer has a byte
//     in_ready   out  FIFO can accept (fifo_count < DEPTH)
//     in_data    in   producer byte
//     load_en    out  registered one-cycle load strobe to the rotator
//     load_data  out  registered byte for the rotator
//     busy       out  FSM is not IDLE
//     fifo_count out  number of bytes currently buffered
module rotator_load_sched #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 8
) (
  input  logic                     clk,
  input  logic                     reset,
`ifdef ROTATOR_LOAD_SCHED_FLUSH_EN
  input  logic                     flush,
`endif
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     load_en,
  output logic [DATA_W-1:0]        load_data,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  // One spare code so that HOLD_CYCLES = 1 still gives a non-zero width.
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] HOLD_M1  = CNT_W'(HOLD_CYCLES - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] ROTATE = 2'd2;

  logic [1:0]        state;
  logic [CNT_W-1:0]  hold_cnt;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic flush_i;
  logic push;
  logic pop;
  logic load_slot;

`ifdef ROTATOR_LOAD_SCHED_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  // in_ready comes only from the registered count, with no path from in_valid.
  assign in_ready = (fifo_count < FULL_CNT);
  assign busy     = (state != IDLE);

  // A load may start from IDLE, or when the rotate hold has expired.
  always_comb begin
    load_slot = 1'b0;
    if (state == IDLE) begin
      load_slot = 1'b1;
    end else if (state == ROTATE && hold_cnt == '0) begin
      load_slot = 1'b1;
    end
  end

  assign push = in_valid && in_ready && !flush_i;
  assign pop  = load_slot && (fifo_count != '0) && !flush_i;

  // Storage array. It needs no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // FIFO pointers and occupancy. DEPTH is a power of two, so the pointers
  // wrap naturally.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Scheduler FSM with registered load outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      load_en   <= 1'b0;
      load_data <= '0;
    end else if (flush_i) begin
      // load_data intentionally keeps the last byte issued.
      state    <= IDLE;
      hold_cnt <= '0;
      load_en  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          load_en <= 1'b0;
          if (pop) begin
            state     <= LOAD;
            load_en   <= 1'b1;
            load_data <= mem[rd_ptr];
          end
        end
        LOAD: begin
          state    <= ROTATE;
          load_en  <= 1'b0;
          hold_cnt <= HOLD_M1;
        end
        ROTATE: begin
          load_en <= 1'b0;
          if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
          end else if (pop) begin
            state     <= LOAD;
            load_en   <= 1'b1;
            load_data <= mem[rd_ptr];
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          load_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rotator_load_sched.sv
module tb_rotator_load_sched;

  logic       clk;
  logic       reset;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       load_en;
  logic [7:0] load_data;
  logic       busy;
  logic [2:0] fifo_count;

  rotator_load_sched #(
    .DATA_W(8),
    .DEPTH(4),
    .HOLD_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset(reset),
`ifdef ROTATOR_LOAD_SCHED_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .load_en(load_en),
    .load_data(load_data),
    .busy(busy),
    .fifo_count(fifo_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst;
    logic       v;
    logic [7:0] d;
    logic       e_ready;
    logic [2:0] e_cnt;
    logic       e_le;
    logic [7:0] e_ld;
    logic       e_busy;
  } vec_t;

  vec_t tbl [13];
  int   n_cmp;
  int   n_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one rising edge, then sample away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    flush    = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic       acc;
    logic       prev_le;
    int         k;
    int         acc5_edge;
    int         load_cyc [$];
    logic [7:0] load_dat [$];
    logic [7:0] exp_q [$];
    logic [7:0] e;
    int         sent;
    int         got;
    int         pulses;

    n_cmp    = 0;
    n_err    = 0;
    reset    = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Columns: rst, valid, data | ready, count, load_en, load_data, busy.
    // Row 2 is push edge E. load_en is high after E+1 only, and busy stays
    // high for the following 8 ROTATE cycles.
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 3'd1, 1'b0, 8'h00, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b1, 8'hA5, 1'b1};
    for (int i = 4; i < 12; i++) begin
      tbl[i] = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 8'hA5, 1'b1};
    end
    tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 8'hA5, 1'b0};

    for (int i = 0; i < 13; i++) begin
      reset    = tbl[i].rst;
      in_valid = tbl[i].v;
      in_data  = tbl[i].d;
      step();
      check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(tbl[i].e_ready));
      check($sformatf("v%0d fifo_count", i), 32'(fifo_count), 32'(tbl[i].e_cnt));
      check($sformatf("v%0d load_en", i), 32'(load_en), 32'(tbl[i].e_le));
      check($sformatf("v%0d load_data", i), 32'(load_data), 32'(tbl[i].e_ld));
      check($sformatf("v%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
    end
    in_valid = 1'b0;

    // Backlog and full: push 0x01..0x05 while holding in_valid.
    do_reset();
    in_valid  = 1'b1;
    in_data   = 8'h01;
    k         = 0;
    acc5_edge = -1;
    prev_le   = 1'b0;
    for (int t = 0; t < 56; t++) begin
      acc = in_valid && in_ready;
      step();
      if (acc) begin
        if (k == 4) acc5_edge = t;
        k++;
        if (k == 5) in_valid = 1'b0;
        else in_data = 8'(k + 1);
      end
      if (t == 4) begin
        check("full count", 32'(fifo_count), 32'd4);
        check("full in_ready", 32'(in_ready), 32'd0);
      end
      if (t == 10) check("ready after pop", 32'(in_ready), 32'd1);
      if (load_en) begin
        load_cyc.push_back(t);
        load_dat.push_back(load_data);
        if (prev_le) check("load_en width", 32'd2, 32'd1);
      end
      prev_le = load_en;
    end
    check("byte5 accept edge", 32'(acc5_edge), 32'd4);
    check("backlog loads", 32'(load_cyc.size()), 32'd5);
    for (int i = 0; i < load_cyc.size() && i < 5; i++) begin
      check($sformatf("backlog data%0d", i), 32'(load_dat[i]), 32'(i + 1));
      check($sformatf("backlog cycle%0d", i), 32'(load_cyc[i]), 32'(1 + 9 * i));
    end

    // Wrap-around: 12 bytes offered every third cycle, expect order kept.
    do_reset();
    sent     = 0;
    got      = 0;
    in_valid = 1'b1;
    in_data  = 8'h10;
    for (int t = 0; t < 300 && got < 12; t++) begin
      acc = in_valid && in_ready;
      step();
      if (acc) begin
        exp_q.push_back(in_data);
        sent++;
      end
      if (load_en) begin
        if (exp_q.size() == 0) begin
          check("wrap unexpected load", 32'(load_data), 32'hFFFF);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("wrap load%0d", got), 32'(load_data), 32'(e));
        end
        got++;
      end
      in_valid = (sent < 12) && (t % 3 == 0);
      in_data  = 8'h10 + 8'(sent * 7);
    end
    in_valid = 1'b0;
    check("wrap load total", 32'(got), 32'd12);

    // Reset mid-ROTATE: 3 bytes queued, reset in the 4th ROTATE cycle.
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'hC1 + 8'(i);
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("pre-reset count", 32'(fifo_count), 32'd2);
    check("pre-reset busy", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid reset count", 32'(fifo_count), 32'd0);
    check("mid reset ready", 32'(in_ready), 32'd1);
    check("mid reset load_en", 32'(load_en), 32'd0);
    check("mid reset busy", 32'(busy), 32'd0);
    check("mid reset load_data", 32'(load_data), 32'd0);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (load_en) pulses++;
    end
    check("post reset pulses", 32'(pulses), 32'd0);

`ifdef ROTATOR_LOAD_SCHED_FLUSH_EN
    // Flush during ROTATE with 2 bytes queued; a same-cycle push is dropped.
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'h5A + 8'(i);
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    check("pre-flush count", 32'(fifo_count), 32'd2);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush count", 32'(fifo_count), 32'd0);
    check("flush busy", 32'(busy), 32'd0);
    check("flush load_en", 32'(load_en), 32'd0);
    check("flush load_data", 32'(load_data), 32'h5A);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (load_en) pulses++;
    end
    check("post flush pulses", 32'(pulses), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rotator_load_sched.md
# rotator_load_sched

Upstream feeder for the 8-bit rotate-left register stage. Accepts bytes from a producer over a valid/ready handshake and buffers them in a small FIFO. Each byte is issued to the rotator as a one-cycle `load_en` pulse with `load_data`, then the byte is held off for a fixed number of rotate cycles so the downstream stage completes a full rotation before the next load.

## Interface
- `DATA_W`, 8, byte width; must equal the rotator width.
- `DEPTH`, 4, FIFO entries; power of two, ≥ 2.
- `HOLD_CYCLES`, 8, rotate cycles between consecutive loads; ≥ 1.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  producer has a byte.
- `in_ready`  out  1  FIFO can accept; high when `fifo_count < DEPTH`.
- `in_data`  in  DATA_W  producer byte.
- `load_en`  out  1  one-cycle load strobe to the rotator.
- `load_data`  out  DATA_W  byte for the rotator; valid while `load_en` is high.
- `busy`  out  1  state ≠ IDLE.
- `fifo_count`  out  clog2(DEPTH)+1  bytes currently buffered.

## Operation
- **Push.** `in_valid && in_ready` at a rising edge writes `in_data` at the write pointer.
- **FIFO.** Circular buffer with pointer wrap at `DEPTH`. Pop happens on the edge that enters LOAD.
- **FSM.** IDLE, LOAD, ROTATE.
  - IDLE → LOAD when `fifo_count ≠ 0`. On this edge: pop the head into `load_data` and set `load_en`.
  - LOAD → ROTATE unconditionally. On this edge: clear `load_en` and set the hold counter to `HOLD_CYCLES-1`.
  - ROTATE, counter ≠ 0: decrement the counter.
  - ROTATE, counter = 0: go to LOAD (pop, as above) if `fifo_count ≠ 0`, else go to IDLE.
- **Outputs.** `load_en` and `load_data` are registered. `load_data` holds its last value outside LOAD.
- **Simultaneous push and pop.** `fifo_count` is unchanged, and both pointers advance.
- **Full.** `in_ready` is low, so no push occurs. The pop on the next LOAD-entry edge raises `in_ready` in the following cycle.
- **Empty.** No pop, and the FSM stays in IDLE.
- **Reset.** Reset asserted at any point, including mid-ROTATE, forces:
  - state = IDLE and FIFO empty (pointers and count cleared);
  - `load_en`=0, `load_data`=0, `busy`=0, `fifo_count`=0, `in_ready`=1.

  Bytes in flight are discarded. Memory contents need no reset.

## Timing
- **Latency.** Byte accepted on edge E into an empty FIFO while in IDLE: the FIFO becomes non-empty after E, `load_en` is high from E+1 to E+2, and the rotator captures it at E+2.
- **Load period.** With a backlog, loads are spaced exactly `HOLD_CYCLES+1` cycles apart (1 LOAD + `HOLD_CYCLES` ROTATE).
- **`load_en` width.** Never high for two consecutive cycles.
- **`busy`.** High from the cycle `load_en` first rises through the last ROTATE cycle.
- **`in_ready`.** Depends only on registered `fifo_count`; there is no combinational path from `in_valid`.

## Configuration
- **Macro:** `ROTATOR_LOAD_SCHED_FLUSH_EN`.
- **Defined.** Adds input `flush` (1 bit), synchronous, active-high. When sampled high:
  - FIFO emptied, state → IDLE, `load_en` → 0;
  - a push in the same cycle is dropped;
  - `load_data` keeps its value.

  `reset` takes priority over `flush`.
- **Undefined.** No `flush` port and no flush logic. Behaviour is otherwise identical.

## Test plan
- **Reset values.** Assert `reset` for 2 cycles → all outputs at reset values (`in_ready`=1, `fifo_count`=0, `load_en`=0, `load_data`=0x00).
- **Single byte.** Push 0xA5 at edge E → `load_en`=1 and `load_data`=0xA5 during E+1..E+2 only; `busy` low again after 8 ROTATE cycles.
- **Backlog and full.**
  - Push 0x01, 0x02, 0x03, 0x04, 0x05 back-to-back with `in_valid` held → `in_ready` drops once `fifo_count` hits 4.
  - Loads occur in order, spaced 9 cycles apart.
  - 0x05 is accepted only after the first pop.
- **Wrap-around.** 12 bytes pushed over time → output order exactly matches input order across two pointer wraps.
- **Reset mid-operation.** 3 bytes queued, `reset` asserted in the 4th ROTATE cycle → `fifo_count`=0, no further `load_en` pulses, `in_ready`=1 on the next cycle.
- **Flush (`ROTATOR_LOAD_SCHED_FLUSH_EN`).** `flush` pulsed with 2 bytes queued during ROTATE → FIFO empty and IDLE next cycle, no `load_en`, `load_data` unchanged.
